// File: rtl/checkout_pkg.sv
// checkout_pkg: shared types and constants for the checkout item-code matcher.
//   state_t    - matcher FSM states
//   BCD_MAX    - largest legal BCD digit value
//   ITEM_CNT_W - width of the saturating hit counter
//   sat_inc    - saturating increment for the hit counter
package checkout_pkg;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        COMPARE,
        RESULT
    } state_t;

    localparam int unsigned BCD_MAX    = 9;
    localparam int unsigned ITEM_CNT_W = 8;

    function automatic logic [ITEM_CNT_W-1:0] sat_inc(input logic [ITEM_CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/code_entry_shreg.sv
// code_entry_shreg: collects one item code as a stream of digits.
// The first digit ends up most significant. Tracks how many digits are held and
// whether any of them was outside the BCD range.
//   clk, reset_n - clock, asynchronous active-low reset
//   start        - load digit as the first digit of a new entry
//   shift        - shift digit in below the digits already held
//   digit        - incoming digit
//   entry        - packed entry register
//   last         - the next shifted digit completes the entry
//   full         - all NUM_DIGITS digits are held
//   bad          - sticky: some digit of this entry was > BCD_MAX
module code_entry_shreg
    import checkout_pkg::*;
#(
    parameter int unsigned DIGIT_W    = 4,
    parameter int unsigned NUM_DIGITS = 2,
    localparam int unsigned CODE_W    = DIGIT_W * NUM_DIGITS,
    localparam int unsigned CNT_W     = $clog2(NUM_DIGITS + 1)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               shift,
    input  logic [DIGIT_W-1:0] digit,
    output logic [CODE_W-1:0]  entry,
    output logic               last,
    output logic               full,
    output logic               bad
);

    logic [CODE_W-1:0] entry_q, entry_d, shifted;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              bad_q, bad_d;
    logic              digit_bad;

    assign digit_bad = ({{(32 - DIGIT_W){1'b0}}, digit} > BCD_MAX);

    if (NUM_DIGITS == 1) begin : g_single
        assign shifted = digit;
    end else begin : g_multi
        assign shifted = {entry_q[CODE_W-DIGIT_W-1:0], digit};
    end

    always_comb begin
        entry_d = entry_q;
        count_d = count_q;
        bad_d   = bad_q;
        if (start) begin
            // A new entry discards whatever the previous one left behind.
            entry_d = CODE_W'(digit);
            count_d = CNT_W'(1);
            bad_d   = digit_bad;
        end else if (shift) begin
            entry_d = shifted;
            count_d = count_q + 1'b1;
            bad_d   = bad_q | digit_bad;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            entry_q <= '0;
            count_q <= '0;
            bad_q   <= 1'b0;
        end else begin
            entry_q <= entry_d;
            count_q <= count_d;
            bad_q   <= bad_d;
        end
    end

    assign entry = entry_q;
    assign last  = (count_q == CNT_W'(NUM_DIGITS - 1));
    assign full  = (count_q == CNT_W'(NUM_DIGITS));
    assign bad   = bad_q;

endmodule

// File: rtl/checkout_code_matcher.sv
// checkout_code_matcher: multi-digit item-code recognizer.
// Collects NUM_DIGITS BCD digits over a valid/ready handshake, then scans
// CODE_TABLE one entry per cycle and reports hit/miss, bad digit or timeout.
//   clk, reset_n  - clock, asynchronous active-low reset
//   digit_valid   - digit offered this cycle
//   digit         - digit value, most significant first
//   digit_ready   - high while collecting (IDLE, COLLECT)
//   clear         - abort the entry in progress (COLLECT only)
//   result_valid  - one-cycle pulse, result fields updated
//   match         - last result was a hit
//   match_idx     - matched table index, 0 on miss
//   bad_digit     - last result had a non-BCD digit
//   timeout       - last result was an idle timeout abort
//   items_matched - saturating hit count since reset
module checkout_code_matcher
    import checkout_pkg::*;
#(
    parameter int unsigned DIGIT_W    = 4,
    parameter int unsigned NUM_DIGITS = 2,
    parameter int unsigned NUM_CODES  = 4,
    parameter logic [DIGIT_W*NUM_DIGITS*NUM_CODES-1:0] CODE_TABLE = 32'h3017_4265,
    parameter int unsigned TIMEOUT    = 1000,
    localparam int unsigned CODE_W    = DIGIT_W * NUM_DIGITS,
    localparam int unsigned IDX_W     = (NUM_CODES > 1) ? $clog2(NUM_CODES) : 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  digit_valid,
    input  logic [DIGIT_W-1:0]    digit,
    output logic                  digit_ready,
    input  logic                  clear,
    output logic                  result_valid,
    output logic                  match,
    output logic [IDX_W-1:0]      match_idx,
    output logic                  bad_digit,
    output logic                  timeout,
    output logic [ITEM_CNT_W-1:0] items_matched
);

    localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);

    state_t state_q, state_d;

    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [TMR_W-1:0]      timer_q, timer_d;
    logic                  match_q, match_d;
    logic [IDX_W-1:0]      match_idx_q, match_idx_d;
    logic                  bad_q, bad_d;
    logic                  timeout_q, timeout_d;
    logic [ITEM_CNT_W-1:0] items_q, items_d;

    logic              sh_start, sh_shift;
    logic [CODE_W-1:0] entry;
    logic              entry_last, entry_full, entry_bad;
    logic              hit, scan_last, timed_out;

    logic [CODE_W-1:0] table_arr [NUM_CODES];

    for (genvar g = 0; g < NUM_CODES; g++) begin : g_table
        assign table_arr[g] = CODE_TABLE[g*CODE_W +: CODE_W];
    end

    code_entry_shreg #(
        .DIGIT_W    (DIGIT_W),
        .NUM_DIGITS (NUM_DIGITS)
    ) u_entry (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (sh_start),
        .shift   (sh_shift),
        .digit   (digit),
        .entry   (entry),
        .last    (entry_last),
        .full    (entry_full),
        .bad     (entry_bad)
    );

    assign hit       = entry_full && (entry == table_arr[idx_q]);
    assign scan_last = (idx_q == IDX_W'(NUM_CODES - 1));
    assign timed_out = (timer_q == TMR_W'(TIMEOUT));

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (sh_start) begin
                    state_d = (NUM_DIGITS == 1) ? COMPARE : COLLECT;
                end
            end
            COLLECT: begin
                if (clear) begin
                    state_d = IDLE;
                end else if (sh_shift && entry_last) begin
                    state_d = COMPARE;
                end else if (!sh_shift && timed_out) begin
                    state_d = RESULT;
                end
            end
            COMPARE: begin
                if (entry_bad || hit || scan_last) begin
                    state_d = RESULT;
                end
            end
            RESULT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decoded from the state register, plus shift-register controls
    always_comb begin
        digit_ready  = 1'b0;
        result_valid = 1'b0;
        sh_start     = 1'b0;
        sh_shift     = 1'b0;
        unique case (state_q)
            IDLE: begin
                digit_ready = 1'b1;
                sh_start    = digit_valid;
            end
            COLLECT: begin
                digit_ready = 1'b1;
                // clear wins over a digit offered in the same cycle
                sh_shift    = digit_valid && !clear;
            end
            RESULT: begin
                result_valid = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Scan index, idle timer and result fields. Results are written on the edge
    // into RESULT so they are stable while result_valid is high.
    always_comb begin
        idx_d       = idx_q;
        timer_d     = timer_q;
        match_d     = match_q;
        match_idx_d = match_idx_q;
        bad_d       = bad_q;
        timeout_d   = timeout_q;
        items_d     = items_q;
        unique case (state_q)
            IDLE: begin
                if (sh_start) begin
                    idx_d   = '0;
                    timer_d = '0;
                end
            end
            COLLECT: begin
                if (sh_shift) begin
                    idx_d   = '0;
                    timer_d = '0;
                end else if (!clear) begin
                    if (timed_out) begin
                        match_d     = 1'b0;
                        match_idx_d = '0;
                        bad_d       = 1'b0;
                        timeout_d   = 1'b1;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
            end
            COMPARE: begin
                if (entry_bad) begin
                    match_d     = 1'b0;
                    match_idx_d = '0;
                    bad_d       = 1'b1;
                    timeout_d   = 1'b0;
                end else if (hit) begin
                    // Scan runs upward, so the lowest duplicate index wins.
                    match_d     = 1'b1;
                    match_idx_d = idx_q;
                    bad_d       = 1'b0;
                    timeout_d   = 1'b0;
                    items_d     = sat_inc(items_q);
                end else if (scan_last) begin
                    match_d     = 1'b0;
                    match_idx_d = '0;
                    bad_d       = 1'b0;
                    timeout_d   = 1'b0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx_q       <= '0;
            timer_q     <= '0;
            match_q     <= 1'b0;
            match_idx_q <= '0;
            bad_q       <= 1'b0;
            timeout_q   <= 1'b0;
            items_q     <= '0;
        end else begin
            idx_q       <= idx_d;
            timer_q     <= timer_d;
            match_q     <= match_d;
            match_idx_q <= match_idx_d;
            bad_q       <= bad_d;
            timeout_q   <= timeout_d;
            items_q     <= items_d;
        end
    end

    assign match         = match_q;
    assign match_idx     = match_idx_q;
    assign bad_digit     = bad_q;
    assign timeout       = timeout_q;
    assign items_matched = items_q;

endmodule

// File: tb/tb_checkout_code_matcher.sv
module tb_checkout_code_matcher;

    localparam int unsigned TMO = 8;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       digit_valid;
    logic [3:0] digit;
    logic       digit_ready;
    logic       clear;
    logic       result_valid;
    logic       match;
    logic [1:0] match_idx;
    logic       bad_digit;
    logic       timeout;
    logic [7:0] items_matched;

    always #5 clk = ~clk;

    checkout_code_matcher #(
        .TIMEOUT (TMO)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .digit_valid   (digit_valid),
        .digit         (digit),
        .digit_ready   (digit_ready),
        .clear         (clear),
        .result_valid  (result_valid),
        .match         (match),
        .match_idx     (match_idx),
        .bad_digit     (bad_digit),
        .timeout       (timeout),
        .items_matched (items_matched)
    );

    typedef struct {
        logic       m;
        logic [1:0] idx;
        logic       bad;
        logic       tmo;
        logic [7:0] items;
    } exp_t;

    typedef struct {
        logic [3:0] d0;
        logic [3:0] d1;
        logic       m;
        logic [1:0] idx;
        logic       bad;
        int         lat;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[8];
    int   checks = 0;
    int   errors = 0;
    int   exp_items = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic m, input logic [1:0] idx, input logic bad,
                            input logic tmo);
        exp_t e;
        if (m && exp_items < 255) exp_items++;
        e.m = m; e.idx = idx; e.bad = bad; e.tmo = tmo; e.items = 8'(exp_items);
        sb.push_back(e);
    endtask

    // Two digits back to back; returns just after the edge accepting the last one.
    task automatic send2(input logic [3:0] a, input logic [3:0] b);
        @(negedge clk);
        digit_valid = 1'b1;
        digit       = a;
        @(negedge clk);
        digit       = b;
        @(posedge clk);
        #1 digit_valid = 1'b0;
    endtask

    // Counts cycles after the last accepted digit until result_valid.
    task automatic wait_result(input int exp_lat, input bit busy, input bit junk,
                               input string name);
        int lat;
        lat = -1;
        if (junk) begin
            digit_valid = 1'b1;
            digit       = 4'h5;
        end
        for (int k = 0; k <= int'(TMO) + 4 && lat < 0; k++) begin
            @(negedge clk);
            if (busy && k == 0) chk({name, "_ready_low"}, 32'(digit_ready), 32'd0);
            if (result_valid) begin
                lat         = k;
                digit_valid = 1'b0;
            end
        end
        digit_valid = 1'b0;
        chk({name, "_latency"}, lat, exp_lat);
        @(negedge clk);
        chk({name, "_ready_after"}, 32'(digit_ready), 32'd1);
    endtask

    // Scoreboard consumer
    always @(negedge clk) begin
        exp_t e;
        if (reset_n && result_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: result_valid got 1 expected 0");
            end else begin
                e = sb.pop_front();
                chk("match", 32'(match), 32'(e.m));
                chk("match_idx", 32'(match_idx), 32'(e.idx));
                chk("bad_digit", 32'(bad_digit), 32'(e.bad));
                chk("timeout", 32'(timeout), 32'(e.tmo));
                chk("items_matched", 32'(items_matched), 32'(e.items));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;

        vecs[0] = '{4'h6, 4'h5, 1'b1, 2'd0, 1'b0, 1};
        vecs[1] = '{4'h3, 4'h0, 1'b1, 2'd3, 1'b0, 4};
        vecs[2] = '{4'h9, 4'h9, 1'b0, 2'd0, 1'b0, 4};
        vecs[3] = '{4'hA, 4'h5, 1'b0, 2'd0, 1'b1, 1};
        vecs[4] = '{4'h4, 4'h2, 1'b1, 2'd1, 1'b0, 2};
        vecs[5] = '{4'h1, 4'h7, 1'b1, 2'd2, 1'b0, 3};
        vecs[6] = '{4'h5, 4'h6, 1'b0, 2'd0, 1'b0, 4};
        vecs[7] = '{4'h0, 4'hF, 1'b0, 2'd0, 1'b1, 1};

        reset_n     = 1'b0;
        digit_valid = 1'b0;
        digit       = 4'h0;
        clear       = 1'b0;
        #12;
        chk("rst_ready", 32'(digit_ready), 32'd1);
        chk("rst_valid", 32'(result_valid), 32'd0);
        chk("rst_match", 32'(match), 32'd0);
        chk("rst_idx", 32'(match_idx), 32'd0);
        chk("rst_bad", 32'(bad_digit), 32'd0);
        chk("rst_tmo", 32'(timeout), 32'd0);
        chk("rst_items", 32'(items_matched), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        foreach (vecs[i]) begin
            push_exp(vecs[i].m, vecs[i].idx, vecs[i].bad, 1'b0);
            send2(vecs[i].d0, vecs[i].d1);
            wait_result(vecs[i].lat, 1'b1, 1'b0, $sformatf("vec%0d", i));
        end

        // Digits offered during the scan must be dropped.
        push_exp(1'b1, 2'd3, 1'b0, 1'b0);
        send2(4'h3, 4'h0);
        wait_result(4, 1'b1, 1'b1, "junk_scan");

        // Single digit then silence: timeout.
        push_exp(1'b0, 2'd0, 1'b0, 1'b1);
        @(negedge clk);
        digit_valid = 1'b1;
        digit       = 4'h4;
        @(posedge clk);
        #1 digit_valid = 1'b0;
        wait_result(int'(TMO) + 1, 1'b0, 1'b0, "timeout");

        // clear with a simultaneous digit in COLLECT: no result, back to IDLE.
        @(negedge clk);
        digit_valid = 1'b1;
        digit       = 4'h4;
        @(negedge clk);
        clear = 1'b1;
        digit = 4'h2;
        @(posedge clk);
        #1;
        clear       = 1'b0;
        digit_valid = 1'b0;
        pulses = 0;
        for (int k = 0; k < int'(TMO) + 4; k++) begin
            @(negedge clk);
            if (result_valid) pulses++;
        end
        chk("clear_no_pulse", pulses, 0);
        chk("clear_ready", 32'(digit_ready), 32'd1);
        chk("clear_tmo_held", 32'(timeout), 32'd1);
        push_exp(1'b1, 2'd1, 1'b0, 1'b0);
        send2(4'h4, 4'h2);
        wait_result(2, 1'b1, 1'b0, "after_clear");

        // Reset mid-scan.
        send2(4'h9, 4'h9);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        exp_items = 0;
        chk("mrst_ready", 32'(digit_ready), 32'd1);
        chk("mrst_valid", 32'(result_valid), 32'd0);
        chk("mrst_match", 32'(match), 32'd0);
        chk("mrst_idx", 32'(match_idx), 32'd0);
        chk("mrst_bad", 32'(bad_digit), 32'd0);
        chk("mrst_tmo", 32'(timeout), 32'd0);
        chk("mrst_items", 32'(items_matched), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Saturation of the hit counter.
        for (int n = 0; n < 256; n++) begin
            push_exp(1'b1, 2'd1, 1'b0, 1'b0);
            send2(4'h4, 4'h2);
            wait_result(2, 1'b1, 1'b0, "sat");
        end
        chk("sat_items", 32'(items_matched), 32'd255);

        repeat (3) @(negedge clk);
        chk("sb_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
